// File: rtl/lamp_output_driver.sv
// Lamp conditioning stage for a four-approach junction: sequences green changes through
// amber and all-red clearance, and falls back to flashing amber when a conflicting set is requested.
module lamp_output_driver #(
    parameter logic [15:0] AMBER_CYCLES   = 16'd3,
    parameter logic [15:0] ALL_RED_CYCLES = 16'd2,
    parameter logic [15:0] FLASH_HALF     = 16'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_green,
    output logic       req_ready,
    input  logic       clear_fault,
    output logic [3:0] lamp_r,
    output logic [3:0] lamp_a,
    output logic [3:0] lamp_g,
    output logic       busy,
    output logic       fault,
    output logic [1:0] dbg_state
);

    // Handshake: a request transfers on a rising clk edge where req_valid and req_ready
    // are both high; req_ready is high only in STEADY and nothing is buffered otherwise.

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_STEADY = 2'd1;
    localparam logic [1:0] ST_AMBER  = 2'd2;
    localparam logic [1:0] ST_FLASH  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  cur_g_q, cur_g_d;
    logic [3:0]  target_q, target_d;
    logic        flash_on_q, flash_on_d;

    logic [3:0]  lamp_r_q, lamp_r_d;
    logic [3:0]  lamp_a_q, lamp_a_d;
    logic [3:0]  lamp_g_q, lamp_g_d;
    logic        req_ready_q, busy_q, fault_q;

    logic        accept;
    logic        conflict;
    logic [3:0]  drop;

    assign accept   = req_valid && (state_q == ST_STEADY);
    assign conflict = (req_green[0] | req_green[2]) & (req_green[1] | req_green[3]);
    assign drop     = cur_g_q & ~req_green;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_g_d    = cur_g_q;
        target_d   = target_q;
        flash_on_d = flash_on_q;
        case (state_q)
            ST_STEADY: begin
                if (accept) begin
                    if (conflict) begin
                        state_d    = ST_FLASH;
                        cnt_d      = FLASH_HALF - 16'd1;
                        flash_on_d = 1'b1;
                    end else if (drop != 4'd0) begin
                        target_d = req_green;
                        state_d  = ST_AMBER;
                        cnt_d    = AMBER_CYCLES - 16'd1;
                    end else begin
                        // Pure additions (or an identical set) need no clearance.
                        cur_g_d = req_green;
                    end
                end
            end
            ST_AMBER: begin
                if (cnt_q == 16'd0) begin
                    cur_g_d = cur_g_q & target_q;
                    state_d = ST_CLEAR;
                    cnt_d   = ALL_RED_CYCLES - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == 16'd0) begin
                    cur_g_d = target_q;
                    state_d = ST_STEADY;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_FLASH: begin
                if (clear_fault) begin
                    cur_g_d    = 4'd0;
                    target_d   = 4'd0;
                    state_d    = ST_CLEAR;
                    cnt_d      = ALL_RED_CYCLES - 16'd1;
                    flash_on_d = 1'b0;
                end else if (cnt_q == 16'd0) begin
                    flash_on_d = ~flash_on_q;
                    cnt_d      = FLASH_HALF - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = ALL_RED_CYCLES - 16'd1;
            end
        endcase
    end

    // Lamps are decoded from the next state so the registered outputs line up with it.
    always_comb begin
        lamp_r_d = 4'hF;
        lamp_a_d = 4'h0;
        lamp_g_d = 4'h0;
        case (state_d)
            ST_STEADY, ST_CLEAR: begin
                lamp_g_d = cur_g_d;
                lamp_r_d = ~cur_g_d;
            end
            ST_AMBER: begin
                lamp_g_d = cur_g_d & target_d;
                lamp_a_d = cur_g_d & ~target_d;
                lamp_r_d = ~cur_g_d;
            end
            ST_FLASH: begin
                lamp_r_d = 4'h0;
                lamp_a_d = {4{flash_on_d}};
            end
            default: begin
                lamp_r_d = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= ALL_RED_CYCLES - 16'd1;
            cur_g_q     <= 4'd0;
            target_q    <= 4'd0;
            flash_on_q  <= 1'b0;
            lamp_r_q    <= 4'hF;
            lamp_a_q    <= 4'h0;
            lamp_g_q    <= 4'h0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_g_q     <= cur_g_d;
            target_q    <= target_d;
            flash_on_q  <= flash_on_d;
            lamp_r_q    <= lamp_r_d;
            lamp_a_q    <= lamp_a_d;
            lamp_g_q    <= lamp_g_d;
            req_ready_q <= (state_d == ST_STEADY);
            busy_q      <= (state_d == ST_AMBER) || (state_d == ST_CLEAR);
            fault_q     <= (state_d == ST_FLASH);
        end
    end

    assign lamp_r    = lamp_r_q;
    assign lamp_a    = lamp_a_q;
    assign lamp_g    = lamp_g_q;
    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule

// File: doc/lamp_output_driver.md
# lamp_output_driver

Output-side conditioning stage between the adaptive phase controller and the lamp drivers for four approaches (0=N, 1=E, 2=S, 3=W). It accepts a requested green set over a valid/ready handshake and runs the required safe transition sequence: amber on dropped greens, all-red clearance, then new greens. Conflicting requests latch a fault and switch all approaches to flashing amber until the fault is cleared.

## Interface
- AMBER_CYCLES, 16'd3: amber duration in clk cycles, legal range 1..65535.
- ALL_RED_CYCLES, 16'd2: all-red clearance in clk cycles, legal range 1..65535.
- FLASH_HALF, 16'd4: flash half-period in clk cycles, legal range 1..65535.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  a green-set request is present.
- req_green  input  4  requested green approaches, bit i = approach i.
- req_ready  output  1  block can accept a request this cycle.
- clear_fault  input  1  single-cycle pulse that leaves flash mode.
- lamp_r  output  4  red lamp per approach.
- lamp_a  output  4  amber lamp per approach.
- lamp_g  output  4  green lamp per approach.
- busy  output  1  transition sequence in progress.
- fault  output  1  conflict fault latched; flash mode active.

## Operation
- States: CLEAR (all-red clearance), STEADY, AMBER, FLASH. The 16-bit down-counter `cnt` and the 4-bit current-green register `cur_g` are internal.
- Conflict: a request is in conflict when (req_green[0] | req_green[2]) & (req_green[1] | req_green[3]) is true.
- req_ready = (state == STEADY). A request is accepted on a clk edge where req_valid and req_ready are both high. When req_ready is low, req_valid is ignored and nothing is queued.
- Accept in STEADY, with drop = cur_g & ~req_green and add = req_green & ~cur_g:
  - Conflict: go to FLASH, set fault, leave cur_g unchanged.
  - drop != 0: latch target = req_green, go to AMBER, load cnt = AMBER_CYCLES-1.
  - drop == 0 and add != 0: cur_g <= req_green. Stay in STEADY.
  - req_green == cur_g: no change.
- AMBER: dropped approaches show amber. Kept greens, meaning cur_g & target, stay green. When cnt == 0, set cur_g <= cur_g & target, go to CLEAR, load cnt = ALL_RED_CYCLES-1.
- CLEAR: only kept greens stay green; all other approaches are red. When cnt == 0, set cur_g <= target and go to STEADY.
- FLASH:
  - r = g = 0. All four amber lamps toggle together every FLASH_HALF cycles, starting lit.
  - clear_fault: clear fault, set cur_g = 0, set target = 0, go to CLEAR, load ALL_RED_CYCLES-1.
  - clear_fault outside FLASH is ignored.
- Lamp invariant: outside FLASH, each approach has exactly one of r/a/g set.
- Lamp invariant: lamp_g never shows a conflicting set.
- busy = (state == AMBER || state == CLEAR).

## Timing
- Reset values:
  - Outputs: lamp_r=4'hF, lamp_a=0, lamp_g=0, req_ready=0, busy=1, fault=0.
  - Internal: state=CLEAR, cnt=ALL_RED_CYCLES-1, cur_g=0, target=0.
- Reset is asynchronous at any point, including mid-AMBER or mid-FLASH. Outputs take their reset values immediately.
- All outputs are registered.
- Accept at edge T with drop != 0:
  - T+1: amber on.
  - Amber held AMBER_CYCLES cycles.
  - All-red held ALL_RED_CYCLES cycles.
  - New greens and req_ready=1 at T+1+AMBER_CYCLES+ALL_RED_CYCLES.
- Accept at edge T, add only: new greens at T+1. req_ready stays 1.
- Conflict accepted at edge T: fault=1 and flash amber lit at T+1.
- After reset release: req_ready=1 after ALL_RED_CYCLES cycles.
- clear_fault and rst asserted together: rst wins.

## Test plan
- Reset, defaults (3/2/4) → lamp_r=F for 2 cycles, then req_ready=1 with lamps still all red.
- From all-red, request 4'b0101 → lamp_g=0101 and lamp_r=1010 one cycle after accept; req_ready stays high.
- From 0101, request 4'b1010:
  - Cycles 1-3 after accept: lamp_a=0101, lamp_r=1010.
  - Cycles 4-5: lamp_r=F, busy=1.
  - Cycle 6: lamp_g=1010, req_ready=1.
- From 0101, request 4'b0001:
  - Approach 0 stays green throughout.
  - Approach 2 shows amber for 3 cycles, then red for 2 cycles.
  - Final state lamp_g=0001.
- Request 4'b0011 (conflict):
  - Next cycle fault=1, lamp_g=0, lamp_a=F.
  - lamp_a toggles every 4 cycles.
  - A clear_fault pulse gives 2 cycles all red, then req_ready=1 and fault=0.
- Hold req_valid with 4'b1010 during AMBER → no accept until STEADY. Assert rst mid-AMBER → immediate lamp_r=F, lamp_a=0.
